// File: rtl/booth_r4_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Includes the controller states, the Booth digit set and the iteration count.
package booth_r4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_t;

    // Two multiplier bits are retired per step over WIDTH+2 extended bits.
    function automatic int iter_count(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_mul_if.sv
// Request/response bundle between a requester and the Booth multiplier.
// Handshake: a request is accepted on a rising clk edge where start && ready;
// M, Q and is_signed are sampled only on that edge. done pulses for one cycle
// when P is updated, and P is held until the next completion or reset.
interface booth_r4_mul_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     M;
    logic [WIDTH-1:0]     Q;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   P;

    modport master (
        output start, is_signed, M, Q,
        input  ready, busy, done, P
    );

    modport slave (
        input  start, is_signed, M, Q,
        output ready, busy, done, P
    );
endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps the triplet {q(2i+1), q(2i), q(2i-1)} to a
// digit in {-2, -1, 0, +1, +2}.
module booth_r4_enc
    import booth_r4_pkg::*;
(
    input  logic [2:0] triplet,
    output digit_t     digit
);

    always_comb begin
        digit = ZERO;
        case (triplet)
            3'b000, 3'b111: digit = ZERO;
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier with start/done handshake, runtime
// signed/unsigned mode and a held, registered product.
module booth_r4_mul
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    booth_r4_mul_if.slave      bus,
    output state_t             dbg_state
);

    localparam int EW = WIDTH + 2;
    localparam int AW = EW + 1;
    localparam int FW = AW + EW + 1;
    localparam int N  = iter_count(WIDTH);
    localparam int CW = $clog2(N + 1);

    state_t          state_r;
    state_t          state_n;
    logic            accept;
    logic            step;
    logic            finish;

    logic [EW-1:0]   mx_r;
    logic [AW-1:0]   acc_r;
    logic [EW:0]     q_r;
    logic [CW-1:0]   count_r;
    logic [2*WIDTH-1:0] p_r;

    logic [EW-1:0]   mx_ext;
    logic [EW-1:0]   qx_ext;
    digit_t          digit;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [FW-1:0]   field;
    logic [FW-1:0]   shifted;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count_r == CW'(1)) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                // A request in the DONE cycle starts the next job immediately.
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ready = (state_r == IDLE) || (state_r == DONE);
    assign bus.busy  = (state_r == RUN);
    assign bus.done  = (state_r == DONE);
    assign bus.P     = p_r;
    assign dbg_state = state_r;

    assign mx_ext = bus.is_signed ? {{2{bus.M[WIDTH-1]}}, bus.M} : {2'b00, bus.M};
    assign qx_ext = bus.is_signed ? {{2{bus.Q[WIDTH-1]}}, bus.Q} : {2'b00, bus.Q};

    booth_r4_enc u_enc (
        .triplet (q_r[2:0]),
        .digit   (digit)
    );

    // Two extra extension bits keep +/-2*Mx exact for both operand modes.
    always_comb begin
        addend = '0;
        case (digit)
            ZERO:    addend = '0;
            POS1:    addend = {mx_r[EW-1], mx_r};
            POS2:    addend = {mx_r, 1'b0};
            NEG1:    addend = -{mx_r[EW-1], mx_r};
            NEG2:    addend = -{mx_r, 1'b0};
            default: addend = '0;
        endcase
    end

    assign sum     = acc_r + addend;
    assign field   = {sum, q_r};
    assign shifted = $signed(field) >>> 2;

    always_ff @(posedge clk) begin
        if (reset) begin
            mx_r    <= '0;
            acc_r   <= '0;
            q_r     <= '0;
            count_r <= '0;
            p_r     <= '0;
        end else if (accept) begin
            mx_r    <= mx_ext;
            acc_r   <= '0;
            q_r     <= {qx_ext, 1'b0};
            count_r <= CW'(N);
        end else if (step) begin
            acc_r   <= shifted[FW-1 -: AW];
            q_r     <= shifted[EW:0];
            count_r <= count_r - CW'(1);
            // Bit 0 still holds q(-1); the product starts one bit up.
            if (finish) begin
                p_r <= shifted[2*WIDTH:1];
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul: directed corners, back-to-back,
// mid-run reset and randomized traffic against an arithmetic reference.
module tb_booth_r4_mul;
    import booth_r4_pkg::*;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2 + 1;

    logic   clk = 1'b0;
    logic   reset;
    state_t dbg_state;

    always #5 clk = ~clk;

    booth_r4_mul_if #(.WIDTH(WIDTH)) bus ();

    booth_r4_mul #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    logic check_spacing = 1'b0;
    logic [2*WIDTH-1:0] exp_q[$];
    logic [2*WIDTH-1:0] exp_p;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] ref_mul(input logic s, input logic [WIDTH-1:0] m,
                                                   input logic [WIDTH-1:0] q);
        longint a;
        longint b;
        logic [63:0] pr;
        a  = s ? longint'($signed(m)) : longint'({1'b0, m});
        b  = s ? longint'($signed(q)) : longint'({1'b0, q});
        pr = a * b;
        return pr[2*WIDTH-1:0];
    endfunction

    // Scoreboard: every done pulse must match the oldest accepted request.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_p = exp_q.pop_front();
                check("product", bus.P, exp_p);
            end
            if (check_spacing && last_done_cyc >= 0)
                check("done_spacing", cyc - last_done_cyc, N + 1);
            last_done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 4 * N) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_mul(input string tag, input logic s, input logic [WIDTH-1:0] m,
                          input logic [WIDTH-1:0] q, input logic [2*WIDTH-1:0] expv);
        int lat;
        tick();
        check({tag, "_ready"}, bus.ready, 1);
        bus.start = 1'b1; bus.is_signed = s; bus.M = m; bus.Q = q;
        exp_q.push_back(expv);
        tick();
        bus.start = 1'b0;
        bus.is_signed = 1'($urandom); bus.M = WIDTH'($urandom); bus.Q = WIDTH'($urandom);
        check({tag, "_busy"}, bus.busy, 1);
        wait_done(lat);
        check({tag, "_latency"}, lat, N);
        check({tag, "_p"}, bus.P, expv);
        tick();
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_p_held"}, bus.P, expv);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int accepted;
        logic s;
        logic [WIDTH-1:0] m, q;

        reset = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.M = '0; bus.Q = '0;
        tick();
        tick();
        check("rst_ready", bus.ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_p", bus.P, 16'h0000);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b0;

        do_mul("s_min_sq", 1'b1, 8'h80, 8'h80, 16'h4000);
        do_mul("s_7x_m3",  1'b1, 8'h07, 8'hFD, 16'hFFEB);
        do_mul("u_ff_ff",  1'b0, 8'hFF, 8'hFF, 16'hFE01);
        do_mul("s_ff_ff",  1'b1, 8'hFF, 8'hFF, 16'h0001);

        // Back-to-back with start held high; operands change while busy.
        tick();
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.M = 8'h12; bus.Q = 8'h34;
        exp_q.push_back(16'h03A8);
        tick();
        bus.M = 8'h05; bus.Q = 8'h06;
        exp_q.push_back(16'h001E);
        wait_done(lat);
        check("b2b_latency1", lat, N);
        check("b2b_p1", bus.P, 16'h03A8);
        tick();
        check("b2b_rerun_busy", bus.busy, 1);
        check("b2b_p_held", bus.P, 16'h03A8);
        wait_done(lat);
        check("b2b_spacing", lat + 1, N + 1);
        check("b2b_p2", bus.P, 16'h001E);
        bus.start = 1'b0;
        tick();

        // Reset during the third RUN cycle discards the job and clears P.
        tick();
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.M = 8'h7F; bus.Q = 8'h7F;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("mid_state_run", dbg_state, RUN);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_state_idle", dbg_state, IDLE);
        check("mid_p", bus.P, 16'h0000);
        check("mid_ready", bus.ready, 1);
        check("mid_busy", bus.busy, 0);
        check("mid_done", bus.done, 0);
        for (int i = 0; i < N + 3; i++) tick();

        // Randomized back-to-back traffic; start and operands toggle while busy.
        check_spacing = 1'b1;
        last_done_cyc = -1;
        accepted = 0;
        while (accepted < 10000) begin
            tick();
            if (bus.ready) begin
                s = 1'($urandom); m = WIDTH'($urandom); q = WIDTH'($urandom);
                case ($urandom_range(0, 7))
                    0: m = 8'h80;
                    1: q = 8'hFF;
                    default: ;
                endcase
                bus.start = 1'b1; bus.is_signed = s; bus.M = m; bus.Q = q;
                exp_q.push_back(ref_mul(s, m, q));
                accepted++;
            end else begin
                bus.start = 1'($urandom_range(0, 1));
                bus.is_signed = 1'($urandom); bus.M = WIDTH'($urandom); bus.Q = WIDTH'($urandom);
            end
        end
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4 * N && exp_q.size() != 0; i++) tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        check_spacing = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
